// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: hazard FSM state and the per-stage control bundle.
package cpu_types_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALTED = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_en;
        logic pc_redirect;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_OFF = '0;

    localparam hz_ctrl_t CTRL_RUN = '{
        pc_en: 1'b1, pc_redirect: 1'b0,
        ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
    };

    // Squash everything younger than MEM/WB and steer the PC to the target.
    localparam hz_ctrl_t CTRL_REDIRECT = '{
        pc_en: 1'b1, pc_redirect: 1'b1,
        ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1
    };

    // Hold PC and IF/ID, inject a bubble into ID/EX, let older work drain.
    localparam hz_ctrl_t CTRL_STALL = '{
        pc_en: 1'b0, pc_redirect: 1'b0,
        ifid_en: 1'b0, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0
    };

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline latches and the hazard controller.
interface pipeline_hazard_ctrl_if;
    logic       ihit;
    logic       dhit;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_MemtoReg;
    logic       ex_RegWr;
    logic [4:0] ex_WrDest;
    logic       mem_MemtoReg;
    logic       mem_MemWr;
    logic       mem_beq;
    logic       mem_bne;
    logic       mem_zero;
    logic       mem_jump;
    logic       mem_jreg;
    logic       mem_jal;
    logic       wb_Halt;
    logic       pc_en;
    logic       pc_redirect;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       memwb_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       halted;

    // Datapath side: presents latch fields, consumes controls.
    modport master (
        output ihit, dhit, id_rs, id_rt, ex_MemtoReg, ex_RegWr, ex_WrDest,
               mem_MemtoReg, mem_MemWr, mem_beq, mem_bne, mem_zero,
               mem_jump, mem_jreg, mem_jal, wb_Halt,
        input  pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted
    );

    modport slave (
        input  ihit, dhit, id_rs, id_rt, ex_MemtoReg, ex_RegWr, ex_WrDest,
               mem_MemtoReg, mem_MemWr, mem_beq, mem_bne, mem_zero,
               mem_jump, mem_jreg, mem_jal, wb_Halt,
        output pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted
    );
endinterface

// File: rtl/hazard_detect.sv
// Combinational hazard terms: load-use match, branch/jump taken, data-side wait.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_MemtoReg,
    input  logic       ex_RegWr,
    input  logic [4:0] ex_WrDest,
    input  logic       mem_MemtoReg,
    input  logic       mem_MemWr,
    input  logic       dhit,
    input  logic       mem_beq,
    input  logic       mem_bne,
    input  logic       mem_zero,
    input  logic       mem_jump,
    input  logic       mem_jreg,
    input  logic       mem_jal,
    output logic       load_use,
    output logic       taken,
    output logic       data_wait
);
    // $0 is hardwired, so a load targeting it never produces a dependency.
    assign load_use = ex_MemtoReg & ex_RegWr & (ex_WrDest != REG_ZERO) &
                      ((ex_WrDest == id_rs) | (ex_WrDest == id_rt));

    assign taken = (mem_beq & mem_zero) | (mem_bne & ~mem_zero) |
                   mem_jump | mem_jreg | mem_jal;

    assign data_wait = (mem_MemtoReg | mem_MemWr) & ~dhit;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble/squash/halt controller for the 5-stage pipeline latches.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = $clog2(LOAD_BUBBLES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    pipeline_hazard_ctrl_if.slave bus
);
    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use, taken, data_wait;
    hz_ctrl_t         ctrl;
    logic             halted_c;

    hazard_detect u_detect (
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .ex_MemtoReg  (bus.ex_MemtoReg),
        .ex_RegWr     (bus.ex_RegWr),
        .ex_WrDest    (bus.ex_WrDest),
        .mem_MemtoReg (bus.mem_MemtoReg),
        .mem_MemWr    (bus.mem_MemWr),
        .dhit         (bus.dhit),
        .mem_beq      (bus.mem_beq),
        .mem_bne      (bus.mem_bne),
        .mem_zero     (bus.mem_zero),
        .mem_jump     (bus.mem_jump),
        .mem_jreg     (bus.mem_jreg),
        .mem_jal      (bus.mem_jal),
        .load_use     (load_use),
        .taken        (taken),
        .data_wait    (data_wait)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl     = CTRL_OFF;
        halted_c = 1'b0;
        if (state_q == HALTED) begin
            halted_c = 1'b1;
        end else if (data_wait) begin
            // Whole pipe freezes; EX/MEM holds so a pending redirect retries later.
            ctrl = CTRL_OFF;
        end else if (taken) begin
            ctrl    = CTRL_REDIRECT;
            state_d = RUN;
            cnt_d   = '0;
        end else if (state_q == BUBBLE) begin
            ctrl  = CTRL_STALL;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) state_d = RUN;
        end else if (load_use) begin
            // This cycle is the first bubble; the counter covers the rest.
            ctrl = CTRL_STALL;
            if (LOAD_BUBBLES > 1) begin
                cnt_d   = CNT_W'(LOAD_BUBBLES - 1);
                state_d = BUBBLE;
            end
        end else if (!bus.ihit) begin
            ctrl = CTRL_STALL;
        end else begin
            ctrl = CTRL_RUN;
        end
        if (bus.wb_Halt) state_d = HALTED;
        if (RST) begin
            ctrl     = CTRL_OFF;
            halted_c = 1'b0;
        end
    end

    assign bus.pc_en       = ctrl.pc_en;
    assign bus.pc_redirect = ctrl.pc_redirect;
    assign bus.ifid_en     = ctrl.ifid_en;
    assign bus.idex_en     = ctrl.idex_en;
    assign bus.exmem_en    = ctrl.exmem_en;
    assign bus.memwb_en    = ctrl.memwb_en;
    assign bus.ifid_flush  = ctrl.ifid_flush;
    assign bus.idex_flush  = ctrl.idex_flush;
    assign bus.exmem_flush = ctrl.exmem_flush;
    assign bus.halted      = halted_c;
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Consumer side of the pipeline register bundle. Reads the decoded fields held in the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the cache hit strobes.
- Drives the per-stage enable/flush controls, PC hold and PC redirect, and the sticky halt.
- Sits beside the datapath. Owns every stall, bubble and squash decision so the latches stay plain registers.

Parameters:
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard. Legal values 1..3; 2 is used when no MEM-to-EX forwarding exists.
- CNT_W, $clog2(LOAD_BUBBLES+1), width of the bubble counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- ihit  in  1  instruction fetch data valid this cycle.
- dhit  in  1  data access completed this cycle.
- id_rs  in  5  rs field of the IF/ID imemload.
- id_rt  in  5  rt field of the IF/ID imemload.
- ex_MemtoReg  in  1  instruction in ID/EX is a load.
- ex_RegWr  in  1  instruction in ID/EX writes the register file.
- ex_WrDest  in  5  destination register of the ID/EX instruction.
- mem_MemtoReg  in  1  EX/MEM instruction reads memory.
- mem_MemWr  in  1  EX/MEM instruction writes memory.
- mem_beq, mem_bne, mem_zero  in  1 each  branch controls and zero flag in EX/MEM.
- mem_jump, mem_jreg, mem_jal  in  1 each  jump controls in EX/MEM.
- wb_Halt  in  1  halt has reached MEM/WB.
- pc_en  out  1  PC register load enable.
- pc_redirect  out  1  PC loads the branch/jump target rather than npc.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous clear to a bubble; wins over the enable.
- halted  out  1  sticky halt indication.

Behaviour:
- State register: RUN, BUBBLE, HALTED. Bubble counter is CNT_W bits.
- Reset: RST high asynchronously sets state RUN, counter 0. While RST is high, every enable and flush output is 0, and pc_en, pc_redirect and halted are 0.
- Outputs are combinational from state, counter and inputs. Decisions take effect at the next rising edge; there is zero added latency.
- Priority, highest first:
  1. HALTED: all enables 0, flushes 0, halted=1. Only RST leaves this state. Entry: wb_Halt=1 in any state moves to HALTED at the edge, and halted rises the next cycle.
  2. Data freeze: (mem_MemtoReg|mem_MemWr) & !dhit. All enables 0, pc_en 0, no flush. State and counter hold.
  3. Redirect: taken = (beq&zero)|(bne&!zero)|jump|jreg|jal, all mem_-prefixed. Drives:
     - pc_en=1, pc_redirect=1.
     - ifid_flush=1, idex_flush=1, exmem_flush=1, memwb_en=1.
     - Counter cleared, state to RUN.
     - Applies regardless of ihit.
  4. Load-use: in RUN with ex_MemtoReg & ex_RegWr & ex_WrDest!=0 & (ex_WrDest==id_rs | ex_WrDest==id_rt). Drives:
     - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1.
     - If LOAD_BUBBLES>1: load counter with LOAD_BUBBLES-1 and go to BUBBLE; otherwise stay in RUN.
  5. BUBBLE: same outputs as load-use. Counter decrements each unfrozen cycle; at the edge where it reaches 0, return to RUN.
  6. Fetch stall: RUN & !ihit. pc_en=0, ifid_en=0, idex_flush=1, downstream enables 1.
  7. Normal: all enables 1, pc_en=1, flushes 0, pc_redirect 0.
- Register $0 as destination never causes a stall.
- Simultaneous wb_Halt and redirect: halt wins.
- Simultaneous freeze and redirect: freeze wins; the redirect is re-evaluated next cycle because EX/MEM holds.
- RST mid-BUBBLE: counter cleared immediately, no residual bubble after release.

Decomposition:
- Shared package (cpu_types_pkg) gets hz_state_t {RUN, BUBBLE, HALTED} as a 2-bit enum.
- One combinational sub-module, hazard_detect, holds the load-use compare and the taken computation. The FSM and output mux stay in pipeline_hazard_ctrl.

Test Plan:
- Reset released, ihit=1, no hazards -> all enables 1, pc_en=1, flushes 0, halted=0 every cycle.
- Load to $5 in EX, id_rs=5, LOAD_BUBBLES=2 -> two consecutive cycles of pc_en=0, ifid_en=0, idex_flush=1, then normal. The same stimulus with ex_WrDest=0 gives no stall.
- mem_beq=1, mem_zero=1 -> one cycle of pc_redirect=1 with ifid/idex/exmem_flush=1. With mem_zero=0 there is no redirect, and mem_bne=1 with mem_zero=0 redirects.
- mem_MemtoReg=1, dhit=0 for 3 cycles with a simultaneous load-use -> all enables 0 for 3 cycles, then the bubble sequence starts on the dhit cycle.
- Redirect asserted during BUBBLE (counter=1) -> flush applied, state RUN, no further bubble next cycle.
- wb_Halt=1 together with mem_jump=1 -> HALTED next cycle, halted=1, all enables 0 until RST. RST pulsed mid-HALTED -> outputs 0 asynchronously, then RUN behaviour.
